mole_scheduler: RTL and testbench

// Sequences the whack-a-mole game on the 3x3 light grid. Picks a pseudo-random

---
 rtl/mole_scheduler.sv | 149 ++++++++++++++
 tb/tb_mole_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round sequencer for the 3x3 light grid.
// Picks a non-repeating pseudo-random light per round, times the lit window and scores hits.
module mole_scheduler #(
  parameter int unsigned TICKS_UP   = 50_000_000,
  parameter int unsigned TICKS_GAP  = 25_000_000,
  parameter int unsigned MAX_ROUNDS = 20,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit_valid,
  input  logic [3:0] hit_index,
  output logic [3:0] mole_index,
  output logic       mole_valid,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [7:0] round,
  output logic       game_over
);

  localparam int unsigned   TMAX       = (TICKS_UP > TICKS_GAP) ? TICKS_UP : TICKS_GAP;
  localparam int unsigned   TW         = $clog2(TMAX + 1);
  localparam logic [TW-1:0] UP_LOAD    = TW'(TICKS_UP - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(TICKS_GAP - 1);
  localparam logic [7:0]    LAST_ROUND = 8'(MAX_ROUNDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_PICK, S_UP, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_lfsr, w_lfsr_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [3:0]    r_last, w_last_nxt;
  logic [3:0]    r_mole_index, w_mole_index_nxt;
  logic          r_mole_valid, w_mole_valid_nxt;
  logic          r_hit_pulse, w_hit_pulse_nxt;
  logic          r_miss_pulse, w_miss_pulse_nxt;
  logic [7:0]    r_score, w_score_nxt;
  logic [7:0]    r_round, w_round_nxt;
  logic          r_game_over, w_game_over_nxt;
  logic          w_correct;
  logic          w_round_end;
  logic [3:0]    w_cand;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  assign w_lfsr_nxt = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);

  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_last_nxt       = r_last;
    w_mole_index_nxt = r_mole_index;
    w_hit_pulse_nxt  = 1'b0;
    w_miss_pulse_nxt = 1'b0;
    w_score_nxt      = r_score;
    w_round_nxt      = r_round;
    w_round_end      = 1'b0;
    w_correct        = hit_valid && (hit_index == r_mole_index);
    w_cand           = r_lfsr[3:0];

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_score_nxt = '0;
          w_round_nxt = '0;
          w_last_nxt  = '1;
          w_timer_nxt = GAP_LOAD;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_timer == '0) w_state_nxt = S_PICK;
        else               w_timer_nxt = r_timer - 1'b1;
      end
      S_PICK: begin
        if ((w_cand <= 4'd8) && (w_cand != r_last)) begin
          w_mole_index_nxt = w_cand;
          w_last_nxt       = w_cand;
          w_timer_nxt      = UP_LOAD;
          w_state_nxt      = S_UP;
        end
      end
      S_UP: begin
        // A correct hit wins over a simultaneous timeout
        if (w_correct) begin
          w_hit_pulse_nxt = 1'b1;
          w_score_nxt     = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
          w_round_end     = 1'b1;
        end else if (r_timer == '0) begin
          w_miss_pulse_nxt = 1'b1;
          w_round_end      = 1'b1;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
        if (w_round_end) begin
          w_round_nxt = r_round + 8'd1;
          if (r_round == LAST_ROUND) begin
            w_state_nxt = S_DONE;
          end else begin
            w_timer_nxt = GAP_LOAD;
            w_state_nxt = S_GAP;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_mole_valid_nxt = (w_state_nxt == S_UP);
    w_game_over_nxt  = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_timer      <= '0;
      r_last       <= '1;
      r_mole_index <= '0;
      r_mole_valid <= 1'b0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_score      <= '0;
      r_round      <= '0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_timer      <= w_timer_nxt;
      r_last       <= w_last_nxt;
      r_mole_index <= w_mole_index_nxt;
      r_mole_valid <= w_mole_valid_nxt;
      r_hit_pulse  <= w_hit_pulse_nxt;
      r_miss_pulse <= w_miss_pulse_nxt;
      r_score      <= w_score_nxt;
      r_round      <= w_round_nxt;
      r_game_over  <= w_game_over_nxt;
    end
  end

  assign mole_index = r_mole_index;
  assign mole_valid = r_mole_valid;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign score      = r_score;
  assign round      = r_round;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: round table on a 3-round instance, random play on a 255-round
// instance against a game-level reference model.
module tb_mole_scheduler;

  localparam int T_UP   = 4;
  localparam int T_GAP  = 2;
  localparam int MAX_B  = 255;
  localparam int P_IDLE = 0;
  localparam int P_DARK = 1;
  localparam int P_PICK = 2;
  localparam int P_LIT  = 3;
  localparam int P_OVER = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, hv_a, mv_a, hp_a, mp_a, go_a;
  logic [3:0] hi_a, mi_a;
  logic [7:0] sc_a, rd_a;
  logic       rst_b, start_b, hv_b, mv_b, hp_b, mp_b, go_b;
  logic [3:0] hi_b, mi_b;
  logic [7:0] sc_b, rd_b;

  mole_scheduler #(.TICKS_UP(T_UP), .TICKS_GAP(T_GAP), .MAX_ROUNDS(3), .LFSR_SEED(8'hA5)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .hit_valid(hv_a), .hit_index(hi_a),
    .mole_index(mi_a), .mole_valid(mv_a), .hit_pulse(hp_a), .miss_pulse(mp_a),
    .score(sc_a), .round(rd_a), .game_over(go_a));

  mole_scheduler #(.TICKS_UP(T_UP), .TICKS_GAP(T_GAP), .MAX_ROUNDS(MAX_B), .LFSR_SEED(8'hA5)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .hit_valid(hv_b), .hit_index(hi_b),
    .mole_index(mi_b), .mole_valid(mv_b), .hit_pulse(hp_b), .miss_pulse(mp_b),
    .score(sc_b), .round(rd_b), .game_over(go_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic chk_ok(input string name, input bit ok, input int act, input string req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %s", name, act, req);
  endtask

  function automatic int pack(input logic [3:0] mi, input logic mv, input logic hp,
                              input logic mp, input logic [7:0] sc, input logic [7:0] rd,
                              input logic go);
    return int'({mi, mv, hp, mp, sc, rd, go});
  endfunction

  // One table row describes one round of play on dut_a and the state expected after it.
  typedef struct {
    int hit_cyc;     // lit cycle (1..4) carrying the correct index, 0 = none
    int wrong_cyc;   // lit cycle carrying a wrong index, 0 = none
    int wrong_high;  // wrong index is an out-of-grid value instead of a neighbour
    int exp_hit;
    int exp_miss;
    int exp_score;
    int exp_round;
    int exp_over;
  } rnd_t;

  rnd_t rounds[9];

  task automatic start_game_a(input string tag);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, "_start_clears"}, int'({sc_a, rd_a, go_a, mv_a}), 0);
  endtask

  task automatic run_round(input rnd_t r, input string tag);
    int n = 0;
    int k = 0;
    logic [3:0] mole;
    while (!mv_a && n < 64) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_pulse_width"}, int'({hp_a, mp_a}), 0);
    end
    chk_ok({tag, "_dark_then_lit"}, mv_a && (n >= 3), n, ">=3 cycles before mole lit");
    chk_ok({tag, "_mole_range"}, mi_a <= 4'd8, int'(mi_a), "0..8");
    mole = mi_a;
    while (mv_a && k < 8) begin
      k++;
      hv_a = 1'b0;
      hi_a = 4'd0;
      if (k == r.hit_cyc) begin
        hv_a = 1'b1;
        hi_a = mole;
      end else if (k == r.wrong_cyc) begin
        hv_a = 1'b1;
        hi_a = (r.wrong_high != 0) ? 4'hB : ((mole == 4'd8) ? 4'd0 : mole + 4'd1);
      end
      @(negedge clk);
      hv_a = 1'b0;
      if (mv_a) chk({tag, "_no_pulse_while_lit"}, int'({hp_a, mp_a}), 0);
    end
    chk({tag, "_lit_cycles"}, k, (r.hit_cyc != 0) ? r.hit_cyc : T_UP);
    chk({tag, "_hit_pulse"}, int'(hp_a), r.exp_hit);
    chk({tag, "_miss_pulse"}, int'(mp_a), r.exp_miss);
    chk({tag, "_score"}, int'(sc_a), r.exp_score);
    chk({tag, "_round"}, int'(rd_a), r.exp_round);
    chk({tag, "_game_over"}, int'(go_a), r.exp_over);
    chk({tag, "_mole_index_hold"}, int'(mi_a), int'(mole));
  endtask

  task automatic play_game_a(input string tag, input int first, input int exp_score);
    start_game_a(tag);
    for (int i = 0; i < 3; i++) run_round(rounds[first + i], $sformatf("%s_r%0d", tag, i + 1));
    @(negedge clk);
    chk({tag, "_done_hold"}, int'({hp_a, mp_a, mv_a, go_a, sc_a, rd_a}),
        int'({3'b000, 1'b1, 8'(exp_score), 8'd3}));
  endtask

  // Game-level reference model for dut_b
  int         m_phase;
  int         m_left;
  logic [7:0] m_lfsr;
  logic [3:0] m_mole, m_last;
  logic [7:0] m_score, m_round;
  logic       m_hp, m_mp;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  task automatic model_step(input logic st, input logic hv, input logic [3:0] hi);
    m_hp = 1'b0;
    m_mp = 1'b0;
    case (m_phase)
      P_IDLE, P_OVER: if (st) begin
        m_score = 8'd0;
        m_round = 8'd0;
        m_last  = 4'hF;
        m_phase = P_DARK;
        m_left  = T_GAP;
      end
      P_DARK: begin
        m_left--;
        if (m_left == 0) m_phase = P_PICK;
      end
      P_PICK: if (m_lfsr[3:0] <= 4'd8 && m_lfsr[3:0] != m_last) begin
        m_mole  = m_lfsr[3:0];
        m_last  = m_lfsr[3:0];
        m_phase = P_LIT;
        m_left  = T_UP;
      end
      P_LIT: begin
        m_left--;
        if (hv && hi == m_mole) begin
          m_hp = 1'b1;
          if (m_score != 8'd255) m_score = m_score + 8'd1;
        end else if (m_left == 0) begin
          m_mp = 1'b1;
        end
        if (m_hp || m_mp) begin
          m_round = m_round + 8'd1;
          m_phase = (int'(m_round) == MAX_B) ? P_OVER : P_DARK;
          m_left  = T_GAP;
        end
      end
      default: ;
    endcase
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int         n;
    int         tail;
    bit         forced;
    logic       mv_prev;
    logic [3:0] prev_pick;

    rst_a = 1'b1; start_a = 1'b0; hv_a = 1'b0; hi_a = 4'd0;
    rst_b = 1'b1; start_b = 1'b0; hv_b = 1'b0; hi_b = 4'd0;

    rounds[0] = '{0, 0, 0, 0, 1, 0, 1, 0};
    rounds[1] = '{0, 0, 0, 0, 1, 0, 2, 0};
    rounds[2] = '{0, 0, 0, 0, 1, 0, 3, 1};
    rounds[3] = '{2, 0, 0, 1, 0, 1, 1, 0};
    rounds[4] = '{2, 0, 0, 1, 0, 2, 2, 0};
    rounds[5] = '{2, 0, 0, 1, 0, 3, 3, 1};
    rounds[6] = '{0, 2, 0, 0, 1, 0, 1, 0};
    rounds[7] = '{4, 0, 0, 1, 0, 1, 2, 0};
    rounds[8] = '{3, 1, 1, 1, 0, 2, 3, 1};

    repeat (2) @(negedge clk);
    chk("reset_a", pack(mi_a, mv_a, hp_a, mp_a, sc_a, rd_a, go_a), 0);
    chk("reset_b", pack(mi_b, mv_b, hp_b, mp_b, sc_b, rd_b, go_b), 0);
    rst_a = 1'b0;
    @(negedge clk);

    // Reset asserted between edges while a mole is lit
    start_game_a("t1");
    n = 0;
    while (!mv_a && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk_ok("t1_mole_lit", mv_a, n, "mole lit before reset");
    #2 rst_a = 1'b1;
    #1 chk("t1_async_reset", pack(mi_a, mv_a, hp_a, mp_a, sc_a, rd_a, go_a), 0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("t1_idle_after_reset", pack(mi_a, mv_a, hp_a, mp_a, sc_a, rd_a, go_a), 0);

    play_game_a("t2", 0, 0);
    play_game_a("t3", 3, 3);
    play_game_a("t45", 6, 2);

    // Random play on the 255-round instance
    rst_b     = 1'b0;
    m_phase   = P_IDLE;
    m_left    = 0;
    m_lfsr    = 8'hA5;
    m_mole    = 4'd0;
    m_last    = 4'hF;
    m_score   = 8'd0;
    m_round   = 8'd0;
    m_hp      = 1'b0;
    m_mp      = 1'b0;
    tail      = 0;
    forced    = 1'b0;
    mv_prev   = 1'b0;
    prev_pick = 4'hF;
    for (int cyc = 0; cyc < 4000 && tail < 6; cyc++) begin
      start_b = (cyc == 0) ||
                (($urandom_range(0, 39) == 0) && m_phase != P_OVER && m_phase != P_IDLE);
      hv_b    = ($urandom_range(0, 2) == 0);
      hi_b    = ($urandom_range(0, 1) == 0) ? m_mole : 4'($urandom_range(0, 15));
      if (!forced && m_phase == P_LIT && m_score >= 8'd5) begin
        hv_b = 1'b0;
        force dut_b.r_score = 8'hFF;
        #1 release dut_b.r_score;
        m_score = 8'hFF;
        forced  = 1'b1;
      end
      @(posedge clk);
      model_step(start_b, hv_b, hi_b);
      @(negedge clk);
      chk($sformatf("rand_cycle_%0d", cyc), pack(mi_b, mv_b, hp_b, mp_b, sc_b, rd_b, go_b),
          pack(m_mole, m_phase == P_LIT, m_hp, m_mp, m_score, m_round, m_phase == P_OVER));
      if (mv_b && !mv_prev) begin
        chk_ok("rand_pick_range", mi_b <= 4'd8, int'(mi_b), "0..8");
        chk_ok("rand_pick_no_repeat", mi_b != prev_pick, int'(mi_b), "differs from previous round");
        prev_pick = mi_b;
      end
      mv_prev = mv_b;
      if (m_phase == P_OVER) tail++;
    end
    start_b = 1'b0;
    hv_b    = 1'b0;
    chk("b_final_over_round_score", int'({go_b, rd_b, sc_b}), int'({1'b1, 8'd255, 8'd255}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
